// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes (same as dataMemory DQM),
// FSM states, byte-lane offsets and the alignment check.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ACCESS    = 2'b01,
    ST_RMW_WRITE = 2'b10,
    ST_RESP      = 2'b11
  } lsu_state_e;

  localparam logic [1:0] LANE_OFF_0 = 2'd0;
  localparam logic [1:0] LANE_OFF_1 = 2'd1;
  localparam logic [1:0] LANE_OFF_2 = 2'd2;
  localparam logic [1:0] LANE_OFF_3 = 2'd3;

  // Illegal size counts as misaligned so one check covers both error kinds.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != LANE_OFF_0);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extract/extend and store merge for RMW.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  offset,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  shamt_s;
  logic [31:0] shifted_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign shamt_s   = {offset, 3'b000};
  assign shifted_s = rd_word >> shamt_s;
  assign byte_s    = shifted_s[7:0];
  assign half_s    = offset[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'd0;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      SIZE_HALF: load_data = is_unsigned ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      SIZE_WORD: load_data = rd_word;
      default:   load_data = 32'd0;
    endcase
  end

  always_comb begin
    merged_word = rd_word;
    case (size)
      SIZE_BYTE: merged_word = (rd_word & ~(32'h0000_00FF << shamt_s)) |
                               ({24'd0, wdata[7:0]} << shamt_s);
      SIZE_HALF: merged_word = offset[1] ? {wdata[15:0], rd_word[15:0]}
                                         : {rd_word[31:16], wdata[15:0]};
      SIZE_WORD: merged_word = wdata;
      default:   merged_word = rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed dataMemory, with RMW for
// sub-word stores at nonzero offsets. Perf counters under `LSU_PERF_COUNTERS_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspRdata,
  output logic        rspErr,
  output logic [31:0] memAddress,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  output logic [1:0]  memDQM,
  input  logic [31:0] memReadData,
  output logic [31:0] loadCount,
  output logic [31:0] storeCount,
  output logic [31:0] rmwCount
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  off_q, off_d;
  lsu_size_e   size_q, size_d;
  logic        write_q, write_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  lsu_size_e   mem_dqm_q, mem_dqm_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        req_err_s;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  assign req_err_s = is_misaligned(lsu_size_e'(reqSize), reqAddr[1:0]) ||
                     ({2'b00, reqAddr[31:2]} >= MEM_DEPTH);

  lsu_lane_align u_align (
    .rd_word     (memReadData),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data_s),
    .merged_word (merged_s)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    write_d     = write_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_dqm_d   = mem_dqm_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          off_d       = reqAddr[1:0];
          size_d      = lsu_size_e'(reqSize);
          write_d     = reqWrite;
          uns_d       = reqUnsigned;
          wdata_d     = reqWdata;
          rsp_rdata_d = 32'd0;
          if (req_err_s) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            rsp_err_d   = 1'b0;
            mem_addr_d  = {2'b00, reqAddr[31:2]};
            mem_dqm_d   = lsu_size_e'(reqSize);
            mem_wdata_d = reqWrite ? reqWdata : mem_wdata_q;
            state_d     = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!write_q) begin
          rsp_rdata_d = load_data_s;
          state_d     = ST_RESP;
        end else if (off_q == LANE_OFF_0) begin
          state_d = ST_RESP;
        end else begin
          // dataMemory only writes sub-words into the low lanes, so write back a full word.
          mem_wdata_d = merged_s;
          mem_dqm_d   = SIZE_WORD;
          state_d     = ST_RMW_WRITE;
        end
      end
      ST_RMW_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (rspReady) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      off_q       <= LANE_OFF_0;
      size_q      <= SIZE_WORD;
      write_q     <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_dqm_q   <= SIZE_WORD;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      write_q     <= write_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_dqm_q   <= mem_dqm_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign reqReady       = (state_q == ST_IDLE);
  assign rspValid       = (state_q == ST_RESP);
  assign rspRdata       = rsp_rdata_q;
  assign rspErr         = rsp_err_q;
  assign memAddress     = mem_addr_q;
  assign memWriteData   = mem_wdata_q;
  assign memDQM         = mem_dqm_q;
  assign memWriteEnable = ((state_q == ST_ACCESS) && write_q && (off_q == LANE_OFF_0)) ||
                          (state_q == ST_RMW_WRITE);

`ifdef LSU_PERF_COUNTERS_EN
  logic [31:0] load_count_q, load_count_d;
  logic [31:0] store_count_q, store_count_d;
  logic [31:0] rmw_count_q, rmw_count_d;

  always_comb begin
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    rmw_count_d   = rmw_count_q;
    if ((state_q == ST_ACCESS) && !write_q) begin
      load_count_d = load_count_q + 32'd1;
    end else begin
      load_count_d = load_count_q;
    end
    // Every successful store issues exactly one write pulse, direct or RMW.
    if (memWriteEnable) begin
      store_count_d = store_count_q + 32'd1;
    end else begin
      store_count_d = store_count_q;
    end
    if (state_q == ST_RMW_WRITE) begin
      rmw_count_d = rmw_count_q + 32'd1;
    end else begin
      rmw_count_d = rmw_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_count_q  <= 32'd0;
      store_count_q <= 32'd0;
      rmw_count_q   <= 32'd0;
    end else begin
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
      rmw_count_q   <= rmw_count_d;
    end
  end

  assign loadCount  = load_count_q;
  assign storeCount = store_count_q;
  assign rmwCount   = rmw_count_q;
`else
  assign loadCount  = 32'd0;
  assign storeCount = 32'd0;
  assign rmwCount   = 32'd0;
`endif

endmodule
